fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/chip_z8_pkg.sv | 29 ++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_z8_pkg.sv
// chip_z8 shared definitions: opcode fields,
// two-byte encodings and the length decoder.
package chip_z8_pkg;

  localparam int OPC_CLS_BIT = 7;
  localparam int OPC_FN_HI   = 2;
  localparam int OPC_FN_LO   = 0;

  localparam logic [2:0] FN_STB  = 3'b100;
  localparam logic [2:0] FN_MOVI = 3'b101;

  localparam int QDEPTH_DEF = 4;

  function automatic logic is_two_byte(
    input logic [7:0] op
  );
    logic [2:0] fn;
    fn = op[OPC_FN_HI:OPC_FN_LO];
    return !op[OPC_CLS_BIT] &&
           ((fn == FN_STB) || (fn == FN_MOVI));
  endfunction

  function automatic logic [7:0] instr_len(
    input logic [7:0] op
  );
    return is_two_byte(op) ? 8'd2 : 8'd1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch byte FIFO: push one byte, pop one
// or two, exposes the two head bytes and count.
module fetch_queue #(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  logic [7:0]                i_wdata,
  input  logic                      i_pop,
  input  logic                      i_pop2,
  output logic [7:0]                o_head0,
  output logic [7:0]                o_head1,
  output logic [$clog2(QDEPTH):0]   o_count
);

  localparam int AW = $clog2(QDEPTH);

  logic [7:0]    r_mem [QDEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;

  logic [AW-1:0] w_rd1;
  logic [AW-1:0] w_step;
  logic [AW:0]   w_dec;
  logic [AW:0]   w_inc;
  logic          w_wr;

  assign w_rd1  = r_rd + AW'(1);
  assign w_step = i_pop2 ? AW'(2) : AW'(1);
  assign w_wr   = i_push & ~i_flush;
  assign w_inc  = {{AW{1'b0}}, w_wr};

  assign o_head0 = r_mem[r_rd];
  assign o_head1 = r_mem[w_rd1];
  assign o_count = r_count;

  // bytes popped this cycle
  always_comb begin
    w_dec = '0;
    if (i_pop && !i_flush) begin
      w_dec = i_pop2 ? (AW+1)'(2) : (AW+1)'(1);
    end
  end

  // byte storage, written at the tail
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr] <= i_wdata;
    end
  end

  // pointers and occupancy; flush wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wr <= r_wr + AW'(1);
      end
      if (i_pop) begin
        r_rd <= r_rd + w_step;
      end
      r_count <= r_count + w_inc - w_dec;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction prefetch: byte reads into a small
// queue, length decode and instruction hand-off.
module fetch_unit
  import chip_z8_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_imm,
  output logic [7:0] instr_pc
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] LP_QD = (CW+1)'(QDEPTH);

  logic [7:0]    r_fetch_pc;
  logic [7:0]    r_head_pc;
  logic          r_inflight;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_used;
  logic [7:0]    w_head0;
  logic [7:0]    w_head1;
  logic          w_rd;
  logic          w_push;
  logic          w_pop;
  logic          w_two;
  logic          w_have1;
  logic          w_have2;
  logic          w_valid;

  // a read still returning reserves its slot
  assign w_used  = {1'b0, w_count}
                 + {{CW{1'b0}}, r_inflight};
  assign w_rd    = reset & ~redirect
                 & (w_used < LP_QD);
  // data of a read cut off by redirect is dropped
  assign w_push  = r_inflight & ~redirect;

  assign w_two   = is_two_byte(w_head0);
  assign w_have1 = (w_count != '0);
  assign w_have2 = (w_count > CW'(1));
  assign w_valid = reset & ~redirect
                 & (w_have2 | (w_have1 & ~w_two));
  assign w_pop   = w_valid & instr_ready;

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_wdata (mem_rdata),
    .i_pop   (w_pop),
    .i_pop2  (w_two),
    .o_head0 (w_head0),
    .o_head1 (w_head1),
    .o_count (w_count)
  );

  // fetch/head addresses and in-flight flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= 8'h00;
      r_head_pc  <= 8'h00;
      r_inflight <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_head_pc  <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      if (w_rd) begin
        r_fetch_pc <= r_fetch_pc + 8'd1;
      end
      if (w_pop) begin
        r_head_pc <= r_head_pc + instr_len(w_head0);
      end
    end
  end

  // present head instruction; all zero in reset
  always_comb begin
    mem_rd       = w_rd;
    mem_addr     = 8'h00;
    instr_valid  = w_valid;
    instr_opcode = 8'h00;
    instr_imm    = 8'h00;
    instr_pc     = 8'h00;
    if (reset) begin
      mem_addr     = r_fetch_pc;
      instr_opcode = w_head0;
      instr_imm    = w_two ? w_head1 : 8'h00;
      instr_pc     = r_head_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// fetch_unit bench: directed scenarios plus a
// random phase against an instruction-stream model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_imm;
  logic [7:0] instr_pc;

  logic [7:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  fetch_unit #(.QDEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_imm    (instr_imm),
    .instr_pc     (instr_pc)
  );

  always #5 clk = ~clk;

  // program memory: data one cycle after request
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic bit two_byte(
    input logic [7:0] op
  );
    return (op[7] == 1'b0) &&
           (op[2:0] == 3'd4 || op[2:0] == 3'd5);
  endfunction

  // model: expected instruction / fetch address
  logic [7:0] m_pc  = 8'h00;
  logic [7:0] m_fpc = 8'h00;
  bit         m_hold = 1'b0;
  logic [7:0] h_op, h_imm, h_pc;
  int         pops = 0;

  always @(negedge clk) begin
    logic [7:0] nx;
    logic [7:0] eimm;
    if (!reset) begin
      m_pc   = 8'h00;
      m_fpc  = 8'h00;
      m_hold = 1'b0;
    end else if (redirect) begin
      chk("redir_rd", {31'd0, mem_rd}, 0);
      chk("redir_valid", {31'd0, instr_valid}, 0);
      m_pc   = redirect_pc;
      m_fpc  = redirect_pc;
      m_hold = 1'b0;
    end else begin
      if (mem_rd) begin
        chk("mem_addr", {24'd0, mem_addr},
            {24'd0, m_fpc});
        m_fpc = m_fpc + 8'd1;
      end
      if (m_hold) begin
        chk("hold_valid", {31'd0, instr_valid}, 1);
        chk("hold_op", {24'd0, instr_opcode},
            {24'd0, h_op});
        chk("hold_imm", {24'd0, instr_imm},
            {24'd0, h_imm});
        chk("hold_pc", {24'd0, instr_pc},
            {24'd0, h_pc});
      end
      if (instr_valid) begin
        nx   = m_pc + 8'd1;
        eimm = two_byte(mem[m_pc]) ? mem[nx] : 8'h00;
        chk("ins_pc", {24'd0, instr_pc},
            {24'd0, m_pc});
        chk("ins_op", {24'd0, instr_opcode},
            {24'd0, mem[m_pc]});
        chk("ins_imm", {24'd0, instr_imm},
            {24'd0, eimm});
        if (instr_ready) begin
          pops++;
          m_pc = m_pc + (two_byte(mem[m_pc]) ? 8'd2 : 8'd1);
        end
      end
      m_hold = instr_valid && !instr_ready;
      h_op   = instr_opcode;
      h_imm  = instr_imm;
      h_pc   = instr_pc;
    end
  end

  // called at a negedge; bounded wait for valid
  task automatic wait_valid(input int lim,
                            input string tag);
    int k = 0;
    while (!instr_valid && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, instr_valid}, 1);
  endtask

  // one-cycle redirect, returns at a negedge
  task automatic do_redirect(input logic [7:0] pc);
    @(posedge clk); #1;
    redirect    = 1'b1;
    redirect_pc = pc;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"}, {31'd0, mem_rd}, 0);
    chk({tag, "_addr"}, {24'd0, mem_addr}, 0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 0);
    chk({tag, "_op"}, {24'd0, instr_opcode}, 0);
    chk({tag, "_imm"}, {24'd0, instr_imm}, 0);
    chk({tag, "_pc"}, {24'd0, instr_pc}, 0);
  endtask

  initial begin
    int cnt;
    int k;
    logic [7:0] s_op;
    logic [7:0] s_pc;
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    instr_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mem[i] = 8'h80 + 8'(i);
    mem[8'h10] = 8'h05;
    mem[8'h11] = 8'h3C;
    mem[8'h12] = 8'h90;
    mem[8'h40] = 8'h88;
    mem[8'h41] = 8'h8A;
    mem[8'hFF] = 8'h04;

    // held in reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");

    // release: first read at 0x00
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("first_rd", {31'd0, mem_rd}, 1);
    chk("first_addr", {24'd0, mem_addr}, 0);
    wait_valid(10, "s1_to");
    chk("s1_op", {24'd0, instr_opcode}, 8'h80);
    chk("s1_pc", {24'd0, instr_pc}, 8'h00);
    chk("s1_imm", {24'd0, instr_imm}, 8'h00);
    @(negedge clk);
    chk("s1_valid2", {31'd0, instr_valid}, 1);
    chk("s1_op2", {24'd0, instr_opcode}, 8'h81);
    chk("s1_pc2", {24'd0, instr_pc}, 8'h01);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (instr_valid) cnt++;
    end
    chk("s1_rate", cnt, 8);

    // two-byte movi at 0x10
    do_redirect(8'h10);
    wait_valid(10, "s2_to");
    chk("s2_op", {24'd0, instr_opcode}, 8'h05);
    chk("s2_imm", {24'd0, instr_imm}, 8'h3C);
    chk("s2_pc", {24'd0, instr_pc}, 8'h10);
    @(negedge clk);
    wait_valid(5, "s2_to2");
    chk("s2_pc2", {24'd0, instr_pc}, 8'h12);

    // stalled consumer fills the queue only
    @(posedge clk); #1;
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 8'h20;
    @(posedge clk); #1;
    redirect = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_rd) cnt++;
    end
    chk("s3_reads", cnt, 4);
    chk("s3_valid", {31'd0, instr_valid}, 1);
    chk("s3_pc", {24'd0, instr_pc}, 8'h20);
    s_op = instr_opcode;
    s_pc = instr_pc;
    repeat (3) @(negedge clk);
    chk("s3_op_hold", {24'd0, instr_opcode},
        {24'd0, s_op});
    chk("s3_pc_hold", {24'd0, instr_pc},
        {24'd0, s_pc});
    chk("s3_no_rd", {31'd0, mem_rd}, 0);
    @(posedge clk); #1;
    instr_ready = 1'b1;

    // redirect with a read in flight
    do_redirect(8'h30);
    k = 0;
    while (!mem_rd && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("s4_rd_seen", {31'd0, mem_rd}, 1);
    do_redirect(8'h40);
    wait_valid(10, "s4_to");
    chk("s4_pc", {24'd0, instr_pc}, 8'h40);
    chk("s4_op", {24'd0, instr_opcode}, 8'h88);
    @(negedge clk);
    wait_valid(5, "s4_to2");
    chk("s4_pc2", {24'd0, instr_pc}, 8'h41);

    // immediate wraps from 0xFF to 0x00
    do_redirect(8'hFF);
    wait_valid(10, "s5_to");
    chk("s5_op", {24'd0, instr_opcode}, 8'h04);
    chk("s5_imm", {24'd0, instr_imm}, 8'h80);
    chk("s5_pc", {24'd0, instr_pc}, 8'hFF);
    @(negedge clk);
    wait_valid(5, "s5_to2");
    chk("s5_pc2", {24'd0, instr_pc}, 8'h01);

    // reset pulsed mid-stream
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_rd", {31'd0, mem_rd}, 1);
    chk("rst2_addr", {24'd0, mem_addr}, 0);
    wait_valid(10, "rst2_to");
    chk("rst2_pc", {24'd0, instr_pc}, 8'h00);
    chk("rst2_op", {24'd0, instr_opcode}, 8'h80);

    // random traffic against the model
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      instr_ready = ($urandom_range(3) != 0);
      redirect    = ($urandom_range(39) == 0);
      redirect_pc = 8'($urandom);
    end
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("rnd_progress", {31'd0, pops > 800}, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
